// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson (twisted-ring) counter and its Gray view.
// The functions take a code zero-extended to JMAX bits plus the live width n,
// so one package serves every instance width up to JMAX.
package johnson_pkg;

  localparam int JMAX = 32;

  typedef logic [JMAX-1:0] jcode_t;

  // A Johnson code has at most one boundary between a run of ones and a run
  // of zeros; exactly 2n of the 2^n patterns qualify.
  function automatic logic is_legal_johnson(input jcode_t code, input int n);
    int trans;
    trans = 0;
    for (int i = 0; i < n - 1; i++) begin
      if (code[i] != code[i+1]) trans++;
    end
    return (trans <= 1);
  endfunction

  // Position in the 2n-step ring: filling phase counts ones, draining phase
  // counts down from 2n. Only meaningful for legal codes.
  function automatic int johnson_to_index(input jcode_t code, input int n);
    int pc;
    pc = 0;
    for (int i = 0; i < n; i++) begin
      pc += int'(code[i]);
    end
    return code[n-1] ? (2 * n - pc) : pc;
  endfunction

  // Reflected binary Gray code.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/johnson_to_gray_n.sv
// Combinational decode of an N-bit Johnson code into legality, binary
// position and Gray-coded position.
module johnson_to_gray_n #(
  parameter  int N  = 4,
  localparam int GW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [GW-1:0] idx_o,
  output logic [GW-1:0] g_o
);
  import johnson_pkg::*;

  logic [GW-1:0] idx_w;

  // Decode via the shared package helpers; outputs are garbage for illegal
  // codes and the caller is expected to gate them with legal_o.
  always_comb begin
    idx_w   = GW'(johnson_to_index(JMAX'(code_i), N));
    legal_o = is_legal_johnson(JMAX'(code_i), N);
    idx_o   = idx_w;
    g_o     = GW'(bin_to_gray(32'(idx_w)));
  end

endmodule

// File: rtl/johnson_gray_counter.sv
// N-bit Johnson counter with registered binary index, Gray position, wrap
// pulse and sticky illegal-load flag. Update priority is rst > load > en.
// Index and Gray outputs are decoded from the next state and registered with
// it, so j/idx/g are always mutually consistent.
module johnson_gray_counter #(
  parameter  int N  = 4,
  localparam int GW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_j,
  output logic [N-1:0]  j,
  output logic [GW-1:0] idx,
  output logic [GW-1:0] g,
  output logic          wrap,
  output logic          err
);
  import johnson_pkg::*;

  localparam logic [GW-1:0] LAST_IDX = GW'(2 * N - 1);

  logic [N-1:0]  j_q, j_d;
  logic [GW-1:0] idx_q, idx_d;
  logic [GW-1:0] g_q, g_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [N-1:0]  step_code;
  logic [N-1:0]  cand_code;
  logic          cand_legal;
  logic [GW-1:0] cand_idx;
  logic [GW-1:0] cand_g;

  // Candidate next code: load beats step, otherwise hold the current code.
  always_comb begin
    step_code = dir ? {j_q[N-2:0], ~j_q[N-1]} : {~j_q[0], j_q[N-1:1]};
    if (load)    cand_code = load_j;
    else if (en) cand_code = step_code;
    else         cand_code = j_q;
  end

  johnson_to_gray_n #(.N(N)) u_decode (
    .code_i  (cand_code),
    .legal_o (cand_legal),
    .idx_o   (cand_idx),
    .g_o     (cand_g)
  );

  // Next-state selection: illegal loads collapse to position 0 and raise err;
  // wrap only fires on a step that crosses the ring seam.
  always_comb begin
    j_d    = cand_code;
    idx_d  = cand_idx;
    g_d    = cand_g;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (load) begin
      if (cand_legal) begin
        err_d = 1'b0;
      end else begin
        j_d   = '0;
        idx_d = '0;
        g_d   = '0;
        err_d = 1'b1;
      end
    end else if (en) begin
      wrap_d = dir ? (idx_q == LAST_IDX) : (idx_q == '0);
    end
  end

  // Output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_q    <= '0;
      idx_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      j_q    <= j_d;
      idx_q  <= idx_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign j    = j_q;
  assign idx  = idx_q;
  assign g    = g_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_johnson_gray_counter.sv
// Bench for johnson_gray_counter: an N=4 and an N=3 instance share one clock.
// A position-based model (ring index 0..2N-1 plus err/wrap) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_johnson_gray_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT N=4 ----------------
  logic       r4, e4, d4, l4;
  logic [3:0] lj4;
  logic [3:0] j4;
  logic [2:0] idx4, g4;
  logic       wrap4, err4;

  johnson_gray_counter #(.N(4)) dut4 (
    .clk(clk), .rst(r4), .en(e4), .dir(d4), .load(l4), .load_j(lj4),
    .j(j4), .idx(idx4), .g(g4), .wrap(wrap4), .err(err4)
  );

  // ---------------- DUT N=3 ----------------
  logic       r3, e3, d3, l3;
  logic [2:0] lj3;
  logic [2:0] j3;
  logic [2:0] idx3, g3;
  logic       wrap3, err3;

  johnson_gray_counter #(.N(3)) dut3 (
    .clk(clk), .rst(r3), .en(e3), .dir(d3), .load(l3), .load_j(lj3),
    .j(j3), .idx(idx3), .g(g3), .wrap(wrap3), .err(err3)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // State is just the ring position; the Johnson code is derived from it.
  int m_idx[2];
  int m_err[2];
  int m_wrap[2];

  // Position p of an n-bit ring: p ones filling from the bottom for p<=n,
  // then zeros filling from the bottom.
  function automatic int code_of(input int n, input int p);
    if (p <= n) return (1 << p) - 1;
    return ((1 << n) - 1) & ~((1 << (p - n)) - 1);
  endfunction

  function automatic int find_idx(input int n, input int code);
    for (int p = 0; p < 2 * n; p++) begin
      if (code_of(n, p) == code) return p;
    end
    return -1;
  endfunction

  task automatic model_step(input int k, input int n, input logic r, input logic e,
                            input logic d, input logic l, input int lj);
    int p;
    if (r) begin
      m_idx[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
    end else if (l) begin
      p = find_idx(n, lj);
      m_wrap[k] = 0;
      if (p < 0) begin m_idx[k] = 0; m_err[k] = 1; end
      else       begin m_idx[k] = p; m_err[k] = 0; end
    end else if (e) begin
      if (d) begin
        m_wrap[k] = (m_idx[k] == 2 * n - 1) ? 1 : 0;
        m_idx[k]  = (m_idx[k] + 1) % (2 * n);
      end else begin
        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
        m_idx[k]  = (m_idx[k] + 2 * n - 1) % (2 * n);
      end
    end else begin
      m_wrap[k] = 0;
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic check_all();
    int gx;
    gx = m_idx[0] ^ (m_idx[0] >> 1);
    chk("j4",    32'(j4),    32'(code_of(4, m_idx[0])));
    chk("idx4",  32'(idx4),  32'(m_idx[0]));
    chk("g4",    32'(g4),    32'(gx));
    chk("wrap4", 32'(wrap4), 32'(m_wrap[0]));
    chk("err4",  32'(err4),  32'(m_err[0]));
    gx = m_idx[1] ^ (m_idx[1] >> 1);
    chk("j3",    32'(j3),    32'(code_of(3, m_idx[1])));
    chk("idx3",  32'(idx3),  32'(m_idx[1]));
    chk("g3",    32'(g3),    32'(gx));
    chk("wrap3", 32'(wrap3), 32'(m_wrap[1]));
    chk("err3",  32'(err3),  32'(m_err[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set4(input logic r, input logic e, input logic d, input logic l,
                      input logic [3:0] lj);
    r4 = r; e4 = e; d4 = d; l4 = l; lj4 = lj;
  endtask

  task automatic set3(input logic r, input logic e, input logic d, input logic l,
                      input logic [2:0] lj);
    r3 = r; e3 = e; d3 = d; l3 = l; lj3 = lj;
  endtask

  // One clock: model follows the inputs seen at the edge, outputs are sampled
  // 2 time units later, then the caller may change inputs.
  task automatic cycle();
    @(posedge clk);
    model_step(0, 4, r4, e4, d4, l4, int'(lj4));
    model_step(1, 3, r3, e3, d3, l3, int'(lj3));
    #2;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] gseq4 [8];
  logic [3:0] rnd_lj4;
  logic [2:0] rnd_lj3;

  initial begin
    gseq4 = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    m_idx  = '{0, 0};
    m_err  = '{0, 0};
    m_wrap = '{0, 0};
    set4(1, 0, 1, 0, 4'b0000);
    set3(1, 0, 1, 0, 3'b000);

    // Reset held for two cycles.
    cycle();
    cycle();
    chk("rst_j4", 32'(j4), 32'h0);
    chk("rst_g4", 32'(g4), 32'h0);
    chk("rst_err4", 32'(err4), 32'h0);
    set3(0, 0, 1, 0, 3'b000);

    // Up count through one full ring.
    for (int s = 0; s < 8; s++) begin
      set4(0, 1, 1, 0, 4'b0000);
      cycle();
      chk("up_g4", 32'(g4), 32'(gseq4[s]));
      chk("up_wrap4", 32'(wrap4), (s == 7) ? 32'h1 : 32'h0);
    end
    chk("up_end_j4", 32'(j4), 32'h0);
    set4(0, 0, 1, 0, 4'b0000);
    cycle();
    chk("wrap_one_cycle4", 32'(wrap4), 32'h0);

    // Down step from reset.
    set4(1, 0, 0, 0, 4'b0000);
    cycle();
    set4(0, 1, 0, 0, 4'b0000);
    cycle();
    chk("dn_j4", 32'(j4), 32'h8);
    chk("dn_idx4", 32'(idx4), 32'h7);
    chk("dn_g4", 32'(g4), 32'h4);
    chk("dn_wrap4", 32'(wrap4), 32'h1);
    cycle();
    chk("dn2_j4", 32'(j4), 32'hC);
    chk("dn2_g4", 32'(g4), 32'h5);
    chk("dn2_wrap4", 32'(wrap4), 32'h0);

    // Loads: legal with en, illegal, sticky err, then clearing legal load.
    set4(0, 1, 1, 1, 4'b0111);
    cycle();
    chk("ld_j4", 32'(j4), 32'h7);
    chk("ld_idx4", 32'(idx4), 32'h3);
    chk("ld_g4", 32'(g4), 32'h2);
    set4(0, 0, 1, 1, 4'b0101);
    cycle();
    chk("bad_j4", 32'(j4), 32'h0);
    chk("bad_err4", 32'(err4), 32'h1);
    chk("bad_wrap4", 32'(wrap4), 32'h0);
    for (int s = 0; s < 3; s++) begin
      set4(0, 1, 1, 0, 4'b0000);
      cycle();
      chk("sticky_err4", 32'(err4), 32'h1);
    end
    set4(0, 0, 1, 1, 4'b1110);
    cycle();
    chk("clr_err4", 32'(err4), 32'h0);
    chk("clr_g4", 32'(g4), 32'h7);

    // Reset mid-count at idx 5 with en high.
    set4(1, 0, 1, 0, 4'b0000);
    cycle();
    for (int s = 0; s < 5; s++) begin
      set4(0, 1, 1, 0, 4'b0000);
      cycle();
    end
    chk("pre_rst_idx4", 32'(idx4), 32'h5);
    set4(1, 1, 1, 0, 4'b0000);
    cycle();
    chk("mid_rst_idx4", 32'(idx4), 32'h0);
    chk("mid_rst_wrap4", 32'(wrap4), 32'h0);
    set4(0, 0, 1, 0, 4'b0000);

    // N=3 non-power-of-two wrap.
    set3(1, 0, 1, 0, 3'b000);
    cycle();
    for (int s = 0; s < 6; s++) begin
      set3(0, 1, 1, 0, 3'b000);
      cycle();
      if (s == 4) begin
        chk("n3_idx5", 32'(idx3), 32'h5);
        chk("n3_g5", 32'(g3), 32'h7);
      end
    end
    chk("n3_wrap_g", 32'(g3), 32'h0);
    chk("n3_wrap", 32'(wrap3), 32'h1);

    // Randomised traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      rnd_lj4 = ($urandom_range(0, 1) == 0) ? 4'(code_of(4, $urandom_range(0, 7)))
                                              : 4'($urandom_range(0, 15));
      rnd_lj3 = ($urandom_range(0, 1) == 0) ? 3'(code_of(3, $urandom_range(0, 5)))
                                              : 3'($urandom_range(0, 7));
      set4(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rnd_lj4);
      set3(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rnd_lj3);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/johnson_gray_counter.md
# johnson_gray_counter

Parametrised N-bit Johnson (twisted-ring) counter with a registered Gray-coded position output. It generalises the fixed 4-bit Johnson-to-Gray converter to any width N ≥ 2, and adds the following:
- up/down stepping;
- parallel load with a legality check;
- a wrap pulse;
- a sticky error flag.

It sits after position/phase sequencing logic and feeds Gray-indexed consumers such as clock-domain-safe phase buses.

## Interface
Parameters:
- `N`, default 4: Johnson register width; 2N legal states; must be ≥ 2.
- `GW`, localparam `$clog2(2*N)`: width of the Gray and index outputs.

Ports:
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: step the counter one position this cycle.
- `dir`, input, 1: step direction; 1 = up, 0 = down.
- `load`, input, 1: parallel-load `load_j` this cycle.
- `load_j`, input, N: Johnson code to load.
- `j`, output, N: current Johnson state, registered.
- `idx`, output, GW: binary position 0..2N-1 of `j`, registered.
- `g`, output, GW: Gray code of `idx` (`idx ^ (idx>>1)`), registered.
- `wrap`, output, 1: one-cycle pulse, registered.
- `err`, output, 1: sticky illegal-load flag.

## Operation
- Update priority: `rst` > `load` > `en`. When none is active, hold all state.
- Up step: `j <= {j[N-2:0], ~j[N-1]}`.
- Down step: `j <= {~j[0], j[N-1:1]}`.
- Legal Johnson code: at most one index i in 0..N-2 with `j[i] != j[i+1]`. Exactly 2N codes qualify.
- Index from code:
  - if `j[N-1]==0`, `idx = popcount(j)`;
  - otherwise `idx = 2N - popcount(j)`.
  - For N=4: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
- `idx` and `g` are computed from the next state and registered together with `j`. The three outputs are mutually consistent in every cycle.
- Legal load: `j <= load_j`, `idx` and `g` follow, `err` is cleared.
- Illegal load:
  - `j`, `idx` and `g` are forced to 0;
  - `err` is set to 1;
  - `wrap` stays 0.
- `err` is sticky. Only `rst` or a subsequent legal load clears it. Stepping does not affect `err`.
- `wrap`:
  - asserted for exactly one cycle after an up step from idx 2N-1 to 0;
  - asserted for exactly one cycle after a down step from idx 0 to 2N-1;
  - 0 after loads, holds and reset.
- When 2N is not a power of two, wrapping changes more than one Gray bit (e.g. N=3: idx 5 g=111 → idx 0 g=000). This is permitted, and `wrap` marks the event.

## Timing
- Reset values: `j=0`, `idx=0`, `g=0`, `wrap=0`, `err=0`. These appear at the first rising edge with `rst=1`.
- Latency: one cycle from an `en`/`load` edge to updated `j`/`idx`/`g`/`wrap`/`err`. There is no combinational input→output path.
- `en` may be held high continuously: one step per cycle, no bubbles.
- `load` and `en` in the same cycle: the load is applied and the step is ignored.
- `rst` with `load` or `en`: reset wins. Reset mid-count returns to idx 0 on that edge with no wrap pulse.
- `dir` is sampled only when `en=1` and `load=0`. A change of `dir` between cycles reverses the count immediately.

## Structure
- Shared package `johnson_pkg`:
  - function `is_legal_johnson(N-bit)`;
  - function `johnson_to_index`;
  - function `bin_to_gray`.
- Sub-module `johnson_to_gray_n` (parameter `N`): combinational, Johnson code → {legal, idx, g}. It is instantiated on the next-state value, and its outputs are registered in the top.
- Top: next-state mux (rst/load/step), direction shift logic, wrap detection, and output registers.

## Test plan
- Reset, N=4: hold `rst` 2 cycles → j=0000, idx=0, g=000, wrap=0, err=0.
- Up count, N=4, `en=1`, `dir=1`, 8 cycles → g sequence 001,011,010,110,111,101,100,000. On the 8th step j=0000 and wrap=1 for one cycle only.
- Down step from reset, N=4 → j=1000, idx=7, g=100, wrap=1. A further down step → j=1100, g=101, wrap=0.
- Loads, N=4:
  - `load_j=0111` with `en=1` → j=0111, idx=3, g=010, no step taken;
  - then `load_j=0101` → j=0000, g=000, err=1;
  - err stays 1 over 3 steps;
  - a legal load of 1110 → err=0, g=111.
- Reset mid-count, N=4: `rst` asserted at idx 5 together with `en=1` → next cycle idx=0, g=000, wrap=0.
- Non-power-of-two wrap, N=3: up-count 6 steps from 0 → idx 0..5 then 0. At idx 5, g=111. The next step gives g=000 with wrap=1.
